// File: rtl/memory_pkg.sv
// Shared types and defaults for the data-memory controller and its lane-alignment helper.
package memory_pkg;

  localparam int DEFAULT_DMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'd0,
    MEM_HALF    = 2'd1,
    MEM_WORD    = 2'd2,
    MEM_ILLEGAL = 2'd3
  } e_mem_size;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RSP  = 2'd1,
    RMW_WRITE = 2'd2
  } e_dmem_state;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: formats sub-word loads and merges sub-word stores into an old word.
module dmem_align
  import memory_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] load_word,
  input  logic [1:0]      load_offset,
  input  e_mem_size       load_size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] new_data,
  input  logic [1:0]      store_offset,
  input  e_mem_size       store_size,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = load_word[{load_offset, 3'b000} +: 8];
    half_sel  = load_word[{load_offset[1], 4'b0000} +: 16];
    load_data = load_word;
    case (load_size)
      MEM_BYTE: load_data = {{(XLEN-8){byte_sel[7] & ~load_unsigned}}, byte_sel};
      MEM_HALF: load_data = {{(XLEN-16){half_sel[15] & ~load_unsigned}}, half_sel};
      default:  load_data = load_word;
    endcase
  end

  // Each byte lane independently chooses between the old byte and a byte of the store data.
  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic byte_hit;
    logic half_hit;
    assign byte_hit = (store_size == MEM_BYTE) && (store_offset == LANE);
    assign half_hit = (store_size == MEM_HALF) && (store_offset[1] == LANE[1]);
    assign merged_word[gi*8 +: 8] =
      (store_size == MEM_WORD) ? new_data[gi*8 +: 8] :
      byte_hit                 ? new_data[7:0] :
      half_hit                 ? new_data[(gi%2)*8 +: 8] :
                                 old_word[gi*8 +: 8];
  end

endmodule

// File: rtl/dmem_controller.sv
// Data-memory controller: single-port word SRAM behind the MEM stage, with sub-word
// load formatting, read-modify-write sub-word stores and request error rejection.
module dmem_controller
  import memory_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int DMEM_DEPTH = DEFAULT_DMEM_DEPTH,
  localparam int AW         = $clog2(DMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic            write_en,
  input  logic            l_unsigned,
  input  logic [1:0]      n_bytes,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] r_data,
  output logic            rsp_valid,
  output logic            addr_err,
  output logic            stall,
  output logic            sram_en,
  output logic            sram_we,
  output logic [AW-1:0]   sram_addr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata
);

  e_dmem_state     state_reg, state_next;
  logic [1:0]      offset_reg;
  e_mem_size       size_reg;
  logic            unsigned_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [AW-1:0]   waddr_reg;
  logic [XLEN-1:0] hold_reg;

  e_mem_size       req_size;
  logic            req_err;
  logic            req_ok;
  logic            accept;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign req_size = e_mem_size'(n_bytes);
  assign req_err  = (req_size == MEM_ILLEGAL)
                  || ((req_size == MEM_HALF) && addr[0])
                  || ((req_size == MEM_WORD) && (addr[1:0] != 2'b00))
                  || ({2'b00, addr[XLEN-1:2]} >= XLEN'(DMEM_DEPTH));
  assign req_ok   = req && !req_err;
  assign accept   = (state_reg == IDLE) && (state_next != IDLE);

  dmem_align #(.XLEN(XLEN)) u_align (
    .load_word     (sram_rdata),
    .load_offset   (offset_reg),
    .load_size     (size_reg),
    .load_unsigned (unsigned_reg),
    .load_data     (load_data),
    .old_word      (sram_rdata),
    .new_data      (wdata_reg),
    .store_offset  (offset_reg),
    .store_size    (size_reg),
    .merged_word   (merged_word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      offset_reg   <= 2'b00;
      size_reg     <= MEM_BYTE;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      waddr_reg    <= '0;
      hold_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        offset_reg   <= addr[1:0];
        size_reg     <= req_size;
        unsigned_reg <= l_unsigned;
        wdata_reg    <= w_data;
        waddr_reg    <= addr[AW+1:2];
      end
      if (state_reg == LOAD_RSP) begin
        hold_reg <= load_data;
      end
    end
  end

  // Word stores complete in IDLE; only loads and sub-word stores leave it.
  always_comb begin
    state_next = IDLE;
    if (state_reg == IDLE && req_ok) begin
      if (!write_en) begin
        state_next = LOAD_RSP;
      end else if (req_size != MEM_WORD) begin
        state_next = RMW_WRITE;
      end
    end
  end

  // Outputs are held inactive while reset is asserted so no SRAM write can slip out.
  always_comb begin
    stall      = 1'b0;
    rsp_valid  = 1'b0;
    addr_err   = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = addr[AW+1:2];
    sram_wdata = w_data;
    r_data     = hold_reg;
    if (rstn) begin
      case (state_reg)
        IDLE: begin
          if (req && req_err) begin
            addr_err = 1'b1;
          end else if (req_ok) begin
            sram_en = 1'b1;
            if (write_en && req_size == MEM_WORD) begin
              sram_we = 1'b1;
            end else begin
              stall = 1'b1;
            end
          end
        end
        LOAD_RSP: begin
          rsp_valid = 1'b1;
          r_data    = load_data;
        end
        RMW_WRITE: begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = waddr_reg;
          sram_wdata = merged_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller with a behavioural word SRAM attached.
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        write_en = 1'b0;
  logic        l_unsigned = 1'b0;
  logic [1:0]  n_bytes = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] w_data = '0;
  logic [31:0] r_data;
  logic        rsp_valid, addr_err, stall, sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [1024];
  int          wr_count = 0;
  int          rd_count = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_controller dut (
    .clk(clk), .rstn(rstn), .req(req), .write_en(write_en), .l_unsigned(l_unsigned),
    .n_bytes(n_bytes), .addr(addr), .w_data(w_data), .r_data(r_data),
    .rsp_valid(rsp_valid), .addr_err(addr_err), .stall(stall), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        wr_count <= wr_count + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
        rd_count <= rd_count + 1;
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b0;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic r, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; write_en = we; n_bytes = sz; l_unsigned = uns; addr = a; w_data = d;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          output logic [31:0] data, output int stalls, output int got);
    @(negedge clk);
    drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    stalls = 0; got = 0; data = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall) stalls++;
      if (rsp_valid) begin
        got = 1;
        data = r_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                           output int stalls, output int writes);
    int w0;
    w0 = wr_count;
    @(negedge clk);
    drive(1'b1, 1'b1, sz, 1'b0, a, d);
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (!stall) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    writes = wr_count - w0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h01020304);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin bad++; $display("FAIL reset_sram en=%0b we=%0b exp=0/0", sram_en, sram_we); end
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL reset_r_data got=%h exp=00000000", r_data); end
    req = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    logic [31:0] data;
    int stalls, got;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    #1;
    total++; if (sram_en !== 1'b1 || sram_we !== 1'b1) begin bad++; $display("FAIL sw_en_we got=%0b/%0b exp=1/1", sram_en, sram_we); end
    total++; if (sram_addr !== 10'h010) begin bad++; $display("FAIL sw_addr got=%h exp=010", sram_addr); end
    total++; if (sram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", sram_wdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_stall got=%0b exp=0", stall); end
    @(posedge clk); #1;
    total++; if (mem[16] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[16]); end
    run_load(32'h40, 2'd2, 1'b0, data, stalls, got);
    total++; if (got !== 1 || data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h valid=%0d exp=deadbeef", data, got); end
    total++; if (stalls !== 1) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=1", stalls); end
    @(negedge clk);
    req = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || r_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_hold got=%h valid=%0b exp=deadbeef/0", r_data, rsp_valid); end
  endtask

  task automatic test_byte_loads();
    logic [31:0] la [6] = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h102, 32'h100};
    logic [1:0]  ls [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        lu [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] le [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h000080FF, 32'hFFFF80FF, 32'h00000001};
    logic [31:0] data;
    int stalls, got;
    preload(10'h040, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      run_load(la[i], ls[i], lu[i], data, stalls, got);
      total++;
      if (got !== 1 || data !== le[i] || stalls !== 1) begin
        bad++;
        $display("FAIL subload_%0d addr=%h got=%h valid=%0d stalls=%0d exp=%h/1/1", i, la[i], data, got, stalls, le[i]);
      end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] sa [3] = '{32'h142, 32'h140, 32'h142};
    logic [1:0]  ss [3] = '{2'd0, 2'd1, 2'd1};
    logic [31:0] sd [3] = '{32'h000000AA, 32'hFFFFBEEF, 32'h00005566};
    logic [31:0] se [3] = '{32'h11AA3344, 32'h11AABEEF, 32'h5566BEEF};
    int stalls, writes;
    preload(10'h050, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      run_store(sa[i], ss[i], sd[i], stalls, writes);
      total++;
      if (mem[80] !== se[i] || stalls !== 1 || writes !== 1) begin
        bad++;
        $display("FAIL rmw_%0d mem=%h stalls=%0d writes=%0d exp=%h/1/1", i, mem[80], stalls, writes, se[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [4] = '{32'h42, 32'h41, 32'h40, 32'h1000};
    logic [1:0]  es [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        ew [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int w0, r0;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_count; r0 = rd_count;
      @(negedge clk);
      drive(1'b1, ew[i], es[i], 1'b0, ea[i], 32'h0BADF00D);
      #1;
      total++;
      if (addr_err !== 1'b1 || sram_en !== 1'b0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL err_%0d addr_err=%0b sram_en=%0b stall=%0b exp=1/0/0", i, addr_err, sram_en, stall);
      end
      @(posedge clk); #1;
      total++;
      if (mem[16] !== 32'hDEADBEEF || wr_count !== w0 || rd_count !== r0) begin
        bad++;
        $display("FAIL err_mem_%0d mem=%h writes=%0d reads=%0d exp=deadbeef/0/0", i, mem[16], wr_count - w0, rd_count - r0);
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] data;
    int stalls, got, w0;
    preload(10'h060, 32'hCAFEF00D);
    w0 = wr_count;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h181, 32'h00000055);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_rmw_read_stall got=%0b exp=1", stall); end
    #1 rstn = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || sram_en !== 1'b0 || r_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_rmw_outputs stall=%0b sram_en=%0b r_data=%h exp=0/0/00000000", stall, sram_en, r_data);
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rstn = 1'b1;
    #1;
    total++; if (sram_en !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_rmw_idle sram_en=%0b stall=%0b exp=0/0", sram_en, stall); end
    @(posedge clk); #1;
    total++;
    if (mem[96] !== 32'hCAFEF00D || wr_count !== w0) begin
      bad++;
      $display("FAIL rst_rmw_mem mem=%h writes=%0d exp=cafef00d/0", mem[96], wr_count - w0);
    end
    run_load(32'h181, 2'd0, 1'b1, data, stalls, got);
    total++; if (got !== 1 || data !== 32'h000000F0) begin bad++; $display("FAIL rst_rmw_reload got=%h exp=000000f0", data); end
  endtask

  task automatic test_back_to_back();
    logic        bw [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  bs [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [31:0] ba [5] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h44};
    logic        est [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        erv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] erd [5] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h00000078};
    int w0, r0;
    w0 = wr_count; r0 = rd_count;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, bw[c], bs[c], 1'b1, ba[c], 32'h12345678);
      #1;
      total++;
      if (stall !== est[c] || rsp_valid !== erv[c] || (erv[c] && r_data !== erd[c])) begin
        bad++;
        $display("FAIL b2b_cycle_%0d stall=%0b rsp_valid=%0b r_data=%h exp=%0b/%0b/%h", c, stall, rsp_valid, r_data, est[c], erv[c], erd[c]);
      end
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (wr_count - w0 !== 1 || rd_count - r0 !== 2 || mem[17] !== 32'h12345678) begin
      bad++;
      $display("FAIL b2b_accept writes=%0d reads=%0d mem=%h exp=1/2/12345678", wr_count - w0, rd_count - r0, mem[17]);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_loads();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
